// File: rtl/full_adder_pkg.sv
// full_adder_pkg
//   Shared constants for the full_adder slice.
//   CNT_W_DEFAULT : default width of the carry-event counter.
//   cnt_max(w)    : largest value a w-bit counter can hold (2^w - 1),
//                   used as the saturation point of carry_cnt.
package full_adder_pkg;

  localparam int CNT_W_DEFAULT = 8;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// half_adder
//   Single-bit half adder, purely combinational.
//   Ports:
//     a, b  : addend bits
//     sum   : a ^ b
//     carry : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/full_adder.sv
// full_adder
//   One-bit full adder with a registered output stage, a saturating
//   counter of carry-out cycles and a sticky arithmetic self-check.
//   Parameter:
//     CNT_W     : width of carry_cnt (2..16)
//   Ports:
//     clk       : rising-edge clock for all registers
//     rst       : synchronous active-high reset
//     a, b, cin : addend bits and carry-in
//     sum, cout : combinational sum / carry-out (independent of clk, rst)
//     sum_q     : sum registered, one cycle of latency
//     cout_q    : cout registered, one cycle of latency
//     carry_cnt : number of edges seen with cout_q = 1, saturating at 2^CNT_W-1
//     err       : set when {cout,sum} disagrees with a+b+cin, held until reset
module full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic ab_sum;
  logic ab_carry;
  logic sc_carry;

  // Classic two-half-adder decomposition: the first adds a and b, the
  // second folds in cin; either stage producing a carry yields cout.
  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (ab_sum),
    .carry (ab_carry)
  );

  half_adder u_ha_cin (
    .a     (ab_sum),
    .b     (cin),
    .sum   (sum),
    .carry (sc_carry)
  );

  assign cout = ab_carry | sc_carry;

  // Independent arithmetic reference for the self-check. With X/Z on an
  // input the inequality evaluates to X, and an X condition does not take
  // the branch below, so unknown inputs never set err.
  logic [1:0] ref_val;
  logic       mismatch;

  assign ref_val  = {1'b0, a} + {1'b0, b} + {1'b0, cin};
  assign mismatch = (ref_val != {cout, sum});

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= 1'b0;
      cout_q    <= 1'b0;
      carry_cnt <= '0;
      err       <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      // Counts on the registered carry, so a carry appears in the count
      // one edge after it appears on cout_q.
      if (cout_q && (carry_cnt != CNT_MAX)) begin
        carry_cnt <= carry_cnt + CNT_W'(1);
      end
      if (mismatch) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder
//   Self-checking bench for full_adder with CNT_W = 8. A behavioural model
//   computes expected values from plain arithmetic on the inputs.
module tb_full_adder;

  localparam int CNT_W   = 8;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_run;
  logic rst;
  logic a, b, cin;

  initial begin
    clk     = 1'b0;
    clk_run = 1'b0;
  end

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic             sum, cout, sum_q, cout_q, err;
  logic [CNT_W-1:0] carry_cnt;

  full_adder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .carry_cnt (carry_cnt),
    .err       (err)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks;
  int n_fail;

  int m_sum_q;
  int m_cout_q;
  int m_cnt;
  int m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {cout,sum} straight from the arithmetic definition.
  function automatic int add3(input logic x, input logic y, input logic z);
    return int'(x) + int'(y) + int'(z);
  endfunction

  task automatic check_comb(input string tag);
    int total;
    total = add3(a, b, cin);
    check({tag, "_sum"},  32'(sum),  32'(total % 2));
    check({tag, "_cout"}, 32'(cout), 32'(total / 2));
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sum_q"},  32'(sum_q),     32'(m_sum_q));
    check({tag, "_cout_q"}, 32'(cout_q),    32'(m_cout_q));
    check({tag, "_cnt"},    32'(carry_cnt), 32'(m_cnt));
    check({tag, "_err"},    32'(err),       32'(m_err));
  endtask

  // One rising edge; the model advances using the inputs present before it.
  task automatic tick();
    int total;
    total = add3(a, b, cin);
    @(posedge clk);
    #1;
    if (rst) begin
      m_sum_q  = 0;
      m_cout_q = 0;
      m_cnt    = 0;
      m_err    = 0;
    end else begin
      if (m_cout_q == 1 && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
      m_sum_q  = total % 2;
      m_cout_q = total / 2;
    end
  endtask

  task automatic drive(input logic [2:0] v);
    a   = v[2];
    b   = v[1];
    cin = v[0];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] v;
    logic [1:0] snap;
    int         guard;
    n_checks = 0;
    n_fail   = 0;
    m_sum_q  = 0;
    m_cout_q = 0;
    m_cnt    = 0;
    m_err    = 0;
    rst      = 1'b0;
    drive(3'b000);

    // Combinational truth table with the clock idle.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v);
      #10;
      check_comb($sformatf("tt%0d", i));
    end
    drive(3'b011);
    #10;
    check("tt3_const", 32'({cout, sum}), 32'h2);
    drive(3'b111);
    #10;
    check("tt7_const", 32'({cout, sum}), 32'h3);

    // Reset with all-ones inputs: reset must win over capture.
    clk_run = 1'b1;
    rst     = 1'b1;
    drive(3'b111);
    tick();
    check_regs("reset");
    check_comb("reset_comb");

    // One-cycle latency, then the count follows one edge later.
    rst = 1'b0;
    drive(3'b110);
    tick();
    check("lat_sum_q",  32'(sum_q),  32'h0);
    check("lat_cout_q", 32'(cout_q), 32'h1);
    check("lat_cnt0",   32'(carry_cnt), 32'h0);
    check_regs("lat1");
    tick();
    check("lat_cnt1", 32'(carry_cnt), 32'h1);
    check_regs("lat2");

    // Saturation: hold all ones for 300 edges.
    drive(3'b111);
    for (int i = 0; i < 300; i++) begin
      tick();
      check_regs("sat");
    end
    check("sat_top", 32'(carry_cnt), 32'(CNT_TOP));
    tick();
    check("sat_hold", 32'(carry_cnt), 32'(CNT_TOP));

    // Mid-count reset at carry_cnt = 40.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    guard = 0;
    while (m_cnt != 40 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach40", 32'(carry_cnt), 32'd40);
    snap = {cout, sum};
    rst  = 1'b1;
    #2;
    check("midrst_comb_pre", 32'({cout, sum}), 32'(snap));
    tick();
    check_regs("midrst");
    check("midrst_cnt0", 32'(carry_cnt), 32'h0);
    check("midrst_comb_post", 32'({cout, sum}), 32'(snap));
    rst = 1'b0;
    tick();
    check_regs("resume1");
    tick();
    check_regs("resume2");
    check("resume_cnt1", 32'(carry_cnt), 32'h1);

    // Random inputs, occasional reset.
    for (int i = 0; i < 1000; i++) begin
      drive(3'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 49) == 0);
      #1;
      check_comb("rnd_comb");
      tick();
      check_regs("rnd");
    end
    rst = 1'b0;
    tick();
    check("final_err", 32'(err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter (range 2..16).
REQ-002 clk  input  1  rising-edge clock for all registered logic.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 cin  input  1  carry-in bit.
REQ-007 sum  output  1  combinational sum bit, a XOR b XOR cin.
REQ-008 cout  output  1  combinational carry-out, majority(a,b,cin).
REQ-009 sum_q  output  1  registered copy of sum.
REQ-010 cout_q  output  1  registered copy of cout.
REQ-011 carry_cnt  output  CNT_W  saturating count of cycles with cout_q=1.
REQ-012 err  output  1  sticky self-check mismatch flag.

Function
REQ-013 sum and cout SHALL be purely combinational from a, b, cin, with no dependence on clk or rst; they are valid after propagation delay even with clk undriven.
REQ-014 Truth table: abc 000->sum 0 cout 0; 001,010,100->1/0; 011,101,110->0/1; 111->1/1.
REQ-015 {cout,sum} SHALL equal the 2-bit arithmetic sum a+b+cin for all 8 input combinations.
REQ-016 sum_q/cout_q SHALL capture sum/cout on each rising clk edge; latency exactly 1 cycle.
REQ-017 carry_cnt SHALL increment by 1 on each rising edge where cout_q is 1 and carry_cnt is below 2^CNT_W-1.
REQ-018 carry_cnt SHALL hold at 2^CNT_W-1 (saturate, no wrap) once reached.
REQ-019 Self-check: an independent arithmetic reference (a+b+cin, 2 bits) SHALL be compared every cycle against {cout,sum}.
REQ-020 err SHALL be set on the first rising edge where the comparison mismatches and remain 1 until reset.
REQ-021 X/Z on inputs: no requirement on outputs; err SHALL not be set by X inputs (comparison treats non-01 values as match).

Reset
REQ-022 On a rising edge with rst=1: sum_q=0, cout_q=0, carry_cnt=0, err=0.
REQ-023 rst SHALL take priority over capture, increment and err set in the same cycle.
REQ-024 rst SHALL NOT affect the combinational sum/cout.
REQ-025 Reset asserted mid-operation SHALL clear all registers on the next edge; counting resumes on the first edge after rst deasserts.

Structure
REQ-026 Package full_adder_pkg SHALL hold the CNT_W default and the saturation max-value constant function.
REQ-027 Combinational path SHALL be built from two instances of sub-module half_adder (sum=a^b, carry=a&b) plus an OR for cout.
REQ-028 Registers (output stage, counter, err) SHALL reside in full_adder in a single clocked process.

Verification
REQ-029 Drive {a,b,cin}=0..7, 10 ns apart, clk idle -> sum/cout match REQ-014 each step (e.g. 3->0/1, 7->1/1).
REQ-030 rst=1 one edge, then a=1,b=1,cin=0 -> sum_q=0, cout_q=1 exactly one edge later; carry_cnt=1 one edge after that.
REQ-031 Hold a=b=cin=1 for 300 cycles with CNT_W=8 -> carry_cnt reaches 255 and holds; no wrap to 0.
REQ-032 Assert rst during counting (carry_cnt=40) -> next edge all registers 0; sum/cout unchanged throughout.
REQ-033 Random inputs for 1000 cycles -> err stays 0; {cout,sum}==a+b+cin every cycle.
